// File: rtl/mvtr_pkg.sv
// rtl/mvtr_pkg.sv - shared constants and sizing helpers for the mvtr majority voter
//
// Contents:
//   cnt_w(m)   : width of a per-bit "ones" count for m copies, clog2(m+1)
//   maj_thr(m) : majority threshold m/2; a bit votes 1 when its count exceeds it
//   ERR_CNT_W  : width of the optional mismatch counter

package mvtr_pkg;

    localparam int ERR_CNT_W = 16;

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

    // Strict majority: count > m/2. For even m a tie (count == m/2) stays 0.
    function automatic int maj_thr(input int m);
        return m / 2;
    endfunction

endpackage

// File: rtl/mvtr_bit.sv
// rtl/mvtr_bit.sv - combinational single-bit M-input majority voter
//
// Parameters:
//   M        : number of redundant copies (3..15)
// Ports:
//   bits_i   : in,  M  - one bit from each copy, bit k from copy k
//   vote_o   : out, 1  - strict-majority value of bits_i
//   dis_o    : out, 1  - copies do not all agree

module mvtr_bit
    import mvtr_pkg::*;
#(
    parameter int M = 3
) (
    input  logic [M-1:0] bits_i,
    output logic         vote_o,
    output logic         dis_o
);

    localparam int CW = cnt_w(M);

    logic [CW-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int k = 0; k < M; k++) begin
            cnt = cnt + CW'(bits_i[k]);
        end
    end

    assign vote_o = (cnt > CW'(maj_thr(M)));
    assign dis_o  = (cnt != '0) && (cnt != CW'(M));

endmodule

// File: rtl/mvtr.sv
// rtl/mvtr.sv - registered M-way bitwise majority voter for TMR groups
//
// Parameters:
//   M         : number of redundant copies (3..15)
//   N         : width of each copy in bits (1..1024)
// Ports:
//   clk_i     : in,  1   - clock, rising edge
//   rst_n_i   : in,  1   - asynchronous active-low reset
//   vtr_i     : in,  M*N - packed copies, copy k at [k*N+N-1 : k*N]
//   vtr_o     : out, N   - voted word, one cycle after the sample
//   warn_o    : out, 1   - copies disagreed in the sampled cycle (not sticky)
//   err_cnt_o : out, 16  - saturating mismatch counter (only with MVTR_ERR_CNT_EN)
// Build option:
//   MVTR_ERR_CNT_EN - adds err_cnt_o and its counter

module mvtr
    import mvtr_pkg::*;
#(
    parameter int M = 3,
    parameter int N = 32
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic [M*N-1:0] vtr_i,
    output logic [N-1:0]   vtr_o,
    output logic           warn_o
`ifdef MVTR_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

    logic [M-1:0] col [N];
    logic [N-1:0] vote_d;
    logic [N-1:0] dis_d;
    logic         warn_d;

    // Transpose the packed copies into one M-bit column per output bit.
    for (genvar b = 0; b < N; b++) begin : g_bit
        for (genvar k = 0; k < M; k++) begin : g_copy
            assign col[b][k] = vtr_i[k*N + b];
        end

        mvtr_bit #(.M(M)) u_bit (
            .bits_i (col[b]),
            .vote_o (vote_d[b]),
            .dis_o  (dis_d[b])
        );
    end

    assign warn_d = |dis_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vtr_o  <= '0;
            warn_o <= 1'b0;
        end else begin
            vtr_o  <= vote_d;
            warn_o <= warn_d;
        end
    end

`ifdef MVTR_ERR_CNT_EN
    // Counts edges where the sampled copies disagree; holds at all-ones.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt_o <= '0;
        end else if (warn_d && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mvtr.sv
// tb/tb_mvtr.sv - scoreboard testbench for mvtr (M=3/N=32 and M=4/N=8 instances)

module tb_mvtr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] vtr3 = '0;
    logic [31:0] out3;
    logic        warn3;
    logic [31:0] vtr4 = '0;
    logic [7:0]  out4;
    logic        warn4;
`ifdef MVTR_ERR_CNT_EN
    logic [15:0] cnt3;
    logic [15:0] cnt4;
`endif

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] v;
        logic        w;
    } exp_t;

    exp_t q3[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    mvtr #(.M(3), .N(32)) dut3 (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .vtr_i     (vtr3),
        .vtr_o     (out3),
        .warn_o    (warn3)
`ifdef MVTR_ERR_CNT_EN
        ,
        .err_cnt_o (cnt3)
`endif
    );

    mvtr #(.M(4), .N(8)) dut4 (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .vtr_i     (vtr4),
        .vtr_o     (out4),
        .warn_o    (warn4)
`ifdef MVTR_ERR_CNT_EN
        ,
        .err_cnt_o (cnt4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one sample, queue its expectation, and compare after the capturing edge.
    task automatic step3(input string tag, input logic [95:0] v, input logic [31:0] e, input logic w);
        exp_t x;
        @(negedge clk);
        vtr3 = v;
        q3.push_back('{v: e, w: w});
        @(posedge clk);
        #1;
        x = q3.pop_front();
        check({tag, "_vtr"}, 64'(out3), 64'(x.v));
        check({tag, "_warn"}, 64'(warn3), 64'(x.w));
    endtask

    task automatic step4(input string tag, input logic [31:0] v, input logic [7:0] e, input logic w);
        exp_t x;
        @(negedge clk);
        vtr4 = v;
        q4.push_back('{v: 32'(e), w: w});
        @(posedge clk);
        #1;
        x = q4.pop_front();
        check({tag, "_vtr"}, 64'(out4), 64'(x.v));
        check({tag, "_warn"}, 64'(warn4), 64'(x.w));
    endtask

    // Reference M=3 vote written as pairwise AND-OR.
    function automatic logic [31:0] maj3(input logic [95:0] v);
        logic [31:0] a, b, c;
        a = v[95:64];
        b = v[63:32];
        c = v[31:0];
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic dis3(input logic [95:0] v);
        return |((v[95:64] ^ v[63:32]) | (v[95:64] ^ v[31:0]));
    endfunction

    function automatic logic [8:0] ref4(input logic [31:0] v);
        logic [7:0] r;
        logic       d;
        int         c;
        r = '0;
        d = 1'b0;
        for (int b = 0; b < 8; b++) begin
            c = 0;
            for (int k = 0; k < 4; k++) c += int'(v[k*8 + b]);
            r[b] = (c >= 3);
            if (c != 0 && c != 4) d = 1'b1;
        end
        return {d, r};
    endfunction

    initial begin
        logic [95:0] rv;
        logic [31:0] rv4;
        logic [8:0]  r4;

        // Reset holds outputs low regardless of inputs and clock.
        rst_n = 1'b0;
        vtr3  = {3{32'hFFFF_FFFF}};
        vtr4  = {4{8'hFF}};
        repeat (3) @(posedge clk);
        #1;
        check("rst_vtr", 64'(out3), 64'h0);
        check("rst_warn", 64'(warn3), 64'h0);
        check("rst_vtr4", 64'(out4), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step3("rel", {3{32'hFFFF_FFFF}}, 32'hFFFF_FFFF, 1'b0);

        step3("agree", {3{32'h0000_00FF}}, 32'h0000_00FF, 1'b0);
        step3("zero", {3{32'h0}}, 32'h0, 1'b0);
        step3("mixed", {32'h1000, 32'h1100, 32'h0100}, 32'h0000_1100, 1'b1);
        step3("upset_c", {32'h0, 32'h0, 32'h8000_0001}, 32'h0, 1'b1);
        step3("upset_a", {32'h8000_0001, 32'h0, 32'h0}, 32'h0, 1'b1);
        step3("upset_b", {32'h0, 32'h8000_0001, 32'h0}, 32'h0, 1'b1);
        step3("agree2", {3{32'hA5A5_5A5A}}, 32'hA5A5_5A5A, 1'b0);
        step3("two_dev", {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0}, 32'hFFFF_FFFF, 1'b1);

        step4("tie", {8'hF0, 8'hF0, 8'h0F, 8'h0F}, 8'h00, 1'b1);
        step4("three_one", {8'hFF, 8'hFF, 8'hFF, 8'h00}, 8'hFF, 1'b1);
        step4("agree4", {4{8'h3C}}, 8'h3C, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rv = {$urandom(), $urandom(), $urandom()};
            if (i % 4 == 0) rv[63:32] = rv[95:64];
            step3("rand3", rv, maj3(rv), dis3(rv));
            rv4 = $urandom();
            r4 = ref4(rv4);
            step4("rand4", rv4, r4[7:0], r4[8]);
        end

        // Reset mid-stream: outputs clear immediately, in-flight sample is dropped.
        step3("pre_rst", {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0}, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        vtr3 = {32'h0, 32'hFFFF, 32'hFFFF};
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vtr", 64'(out3), 64'h0);
        check("mid_rst_warn", 64'(warn3), 64'h0);
        @(posedge clk);
        #1;
        check("mid_rst_hold", 64'(out3), 64'h0);
        @(negedge clk);
        vtr3  = '0;
        vtr4  = '0;
        rst_n = 1'b1;
        step3("post_rst", {32'h0, 32'h0, 32'h1}, 32'h0, 1'b1);

`ifdef MVTR_ERR_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        vtr3  = '0;
        #1;
        check("cnt_rst", 64'(cnt3), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("cnt_idle", 64'(cnt3), 64'h0);
        for (int i = 0; i < 5; i++) begin
            vtr3 = {32'h0, 32'h0, 32'(i + 1)};
            @(negedge clk);
        end
        vtr3 = {3{32'h1234_5678}};
        repeat (3) @(negedge clk);
        check("cnt_five", 64'(cnt3), 64'd5);
        vtr3 = {32'h0, 32'h0, 32'h4};
        repeat (70000) @(negedge clk);
        check("cnt_sat", 64'(cnt3), 64'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("cnt_mid_rst", 64'(cnt3), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
